// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline stage: issues aligned data-memory requests for RV32I
// loads/stores, extends load data, and drives the register-file write port.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_reg_write,
  input  logic [31:0] in_alu_result,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_wdata,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t      state, state_next;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic [31:0] alu_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [2:0]  funct3_q;
  logic [31:0] store_q;
  logic [31:0] load_q;
  logic        mem_err_q;

  logic        accept;
  logic        in_is_mem;
  logic        in_illegal;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_ext;

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign in_is_mem = in_mem_read || in_mem_write;

  // Illegal covers read+write together, unsupported funct3 and misalignment.
  always_comb begin
    in_illegal = 1'b0;
    if (in_mem_read && in_mem_write) begin
      in_illegal = 1'b1;
    end else if (in_mem_read) begin
      case (in_funct3)
        3'b000, 3'b100: in_illegal = 1'b0;
        3'b001, 3'b101: in_illegal = in_alu_result[0];
        3'b010:         in_illegal = |in_alu_result[1:0];
        default:        in_illegal = 1'b1;
      endcase
    end else if (in_mem_write) begin
      case (in_funct3)
        3'b000:  in_illegal = 1'b0;
        3'b001:  in_illegal = in_alu_result[0];
        3'b010:  in_illegal = |in_alu_result[1:0];
        default: in_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_is_mem)      state_next = WB;
          else if (in_illegal) state_next = IDLE;
          else                 state_next = REQ;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_next = mem_write_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem_rsp_valid) state_next = WB;
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (alu_q[1:0])
      2'd0:    rsp_byte = dmem_rsp_rdata[7:0];
      2'd1:    rsp_byte = dmem_rsp_rdata[15:8];
      2'd2:    rsp_byte = dmem_rsp_rdata[23:16];
      default: rsp_byte = dmem_rsp_rdata[31:24];
    endcase
    rsp_half = alu_q[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{rsp_byte[7]}}, rsp_byte};
      3'b100:  load_ext = {24'd0, rsp_byte};
      3'b001:  load_ext = {{16{rsp_half[15]}}, rsp_half};
      3'b101:  load_ext = {16'd0, rsp_half};
      default: load_ext = dmem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      alu_q       <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      funct3_q    <= 3'd0;
      store_q     <= 32'd0;
      load_q      <= 32'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state     <= state_next;
      mem_err_q <= accept && in_is_mem && in_illegal;
      if (accept) begin
        rd_q        <= in_rd_addr;
        reg_write_q <= in_reg_write;
        alu_q       <= in_alu_result;
        mem_read_q  <= in_mem_read;
        mem_write_q <= in_mem_write;
        funct3_q    <= in_funct3;
        store_q     <= in_store_data;
      end
      if (state == WAIT && dmem_rsp_valid) load_q <= load_ext;
    end
  end

  // Byte enables and write data are zero whenever no request is presented.
  always_comb begin
    dmem_req_be    = 4'b0000;
    dmem_req_wdata = 32'd0;
    if (state == REQ) begin
      if (mem_write_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            dmem_req_be    = 4'b0001 << alu_q[1:0];
            dmem_req_wdata = {4{store_q[7:0]}};
          end
          2'b01: begin
            dmem_req_be    = 4'b0011 << alu_q[1:0];
            dmem_req_wdata = {2{store_q[15:0]}};
          end
          default: begin
            dmem_req_be    = 4'b1111;
            dmem_req_wdata = store_q;
          end
        endcase
      end else begin
        dmem_req_be = 4'b1111;
      end
    end
  end

  assign dmem_req_valid = (state == REQ);
  assign dmem_req_we    = mem_write_q;
  assign dmem_req_addr  = {alu_q[31:2], 2'b00};

  assign rf_we      = (state == WB) && reg_write_q && (rd_q != 5'd0);
  assign rf_rd_addr = rd_q;
  assign rf_wdata   = mem_read_q ? load_q : alu_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// operations compared against an arithmetic model of RV32I load/store rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd_addr;
  logic        in_reg_write;
  logic [31:0] in_alu_result;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_store_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .in_alu_result(in_alu_result), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_store_data(in_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .mem_err(mem_err)
  );

  // Reference rules written as plain arithmetic on offsets and lane values.
  function automatic bit model_err(logic mr, logic mw, logic [2:0] f3, logic [31:0] a);
    int unsigned off = a % 4;
    if (mr && mw) return 1'b1;
    if (mr) begin
      if (f3 == 0 || f3 == 4) return 1'b0;
      if (f3 == 1 || f3 == 5) return (off % 2) != 0;
      if (f3 == 2) return off != 0;
      return 1'b1;
    end
    if (mw) begin
      if (f3 == 0) return 1'b0;
      if (f3 == 1) return (off % 2) != 0;
      if (f3 == 2) return off != 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    int unsigned off = a % 4;
    logic [31:0] b = (rdata >> (8 * off)) % 256;
    logic [31:0] h = (rdata >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
    int unsigned off = a % 4;
    if (f3 == 0) return 4'(1 << off);
    if (f3 == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] sd);
    if (f3 == 0) return (sd % 256) * 32'h0101_0101;
    if (f3 == 1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  // Presents one operation while the stage is idle; returns #1 after the accepting edge.
  task automatic drive_op(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] sd);
    in_reg_write  = rw;
    in_rd_addr    = rd;
    in_alu_result = alu;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_funct3     = f3;
    in_store_data = sd;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 0; in_rd_addr = 0; in_reg_write = 0; in_alu_result = 0;
    in_mem_read = 0; in_mem_write = 0; in_funct3 = 0; in_store_data = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    #3;
    checks++;
    if ({in_ready, dmem_req_valid, rf_we, mem_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {in_ready, dmem_req_valid, rf_we, mem_err});
    end
    checks++;
    if ({dmem_req_be, dmem_req_wdata} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL reset_be_wdata: got %h expected 0", {dmem_req_be, dmem_req_wdata});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_alu_op;
    drive_op(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if ({rf_we, rf_rd_addr, rf_wdata, in_ready} !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      errors++;
      $display("[TB] FAIL alu_wb: got we=%b rd=%0d data=%h rdy=%b expected 1/5/12345678/0",
               rf_we, rf_rd_addr, rf_wdata, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_we, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL alu_after: got we/rdy=%b expected 01", {rf_we, in_ready});
    end
  endtask

  task automatic test_load_byte;
    logic [31:0] expv [2];
    logic [2:0]  f3v  [2];
    expv[0] = 32'hFFFF_FF80; f3v[0] = 3'b000;
    expv[1] = 32'h0000_0080; f3v[1] = 3'b100;
    for (int k = 0; k < 2; k++) begin
      drive_op(1'b1, 5'd7, 32'h0000_0103, 1'b1, 1'b0, f3v[k], 32'h0);
      checks++;
      if ({dmem_req_valid, dmem_req_we, dmem_req_addr} !== {1'b1, 1'b0, 32'h100}) begin
        errors++;
        $display("[TB] FAIL lb_req: got v=%b we=%b addr=%h expected 1/0/00000100",
                 dmem_req_valid, dmem_req_we, dmem_req_addr);
      end
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h80FF_0000;
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      checks++;
      if ({rf_we, rf_rd_addr, rf_wdata} !== {1'b1, 5'd7, expv[k]}) begin
        errors++;
        $display("[TB] FAIL lb_wb[%0d]: got we=%b rd=%0d data=%h expected 1/7/%h",
                 k, rf_we, rf_rd_addr, rf_wdata, expv[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_half;
    drive_op(1'b1, 5'd3, 32'h0000_0202, 1'b0, 1'b1, 3'b001, 32'hAAAA_BEEF);
    for (int c = 0; c < 4; c++) begin
      dmem_req_ready = (c == 3);
      checks++;
      if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata, rf_we} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 1'b0}) begin
        errors++;
        $display("[TB] FAIL sh_hold[%0d]: got v=%b we=%b addr=%h be=%b wd=%h rfwe=%b", c,
                 dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata, rf_we);
      end
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b0;
    checks++;
    if ({in_ready, dmem_req_valid, dmem_req_be, dmem_req_wdata, rf_we} !== {1'b1, 1'b0, 4'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sh_done: got rdy=%b v=%b be=%b wd=%h rfwe=%b expected 1/0/0/0/0",
               in_ready, dmem_req_valid, dmem_req_be, dmem_req_wdata, rf_we);
    end
  endtask

  task automatic test_misaligned;
    drive_op(1'b1, 5'd9, 32'h0000_0101, 1'b1, 1'b0, 3'b010, 32'h0);
    checks++;
    if ({mem_err, dmem_req_valid, rf_we, in_ready} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL lw_misaligned: got err/v/we/rdy=%b expected 1001",
               {mem_err, dmem_req_valid, rf_we, in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_err, dmem_req_valid, rf_we} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL lw_err_pulse: got err/v/we=%b expected 000", {mem_err, dmem_req_valid, rf_we});
    end
  endtask

  task automatic test_rd_zero;
    drive_op(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if ({rf_we, in_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd0_wb: got we/rdy=%b expected 00", {rf_we, in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd0_after: got rdy=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_in_wait;
    drive_op(1'b1, 5'd12, 32'h0000_0400, 1'b1, 1'b0, 3'b010, 32'h0);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, rf_we, dmem_req_valid, mem_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL wait_reset_asserted: got %b expected 0000", {in_ready, rf_we, dmem_req_valid, mem_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_reset_release: got rdy=%b expected 1", in_ready);
    end
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rf_we, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL late_rsp_ignored: got we/rdy=%b expected 01", {rf_we, in_ready});
    end
    drive_op(1'b1, 5'd20, 32'h0BAD_F00D, 1'b0, 1'b0, 3'd0, 32'h0);
    checks++;
    if ({rf_we, rf_rd_addr, rf_wdata} !== {1'b1, 5'd20, 32'h0BAD_F00D}) begin
      errors++;
      $display("[TB] FAIL post_reset_op: got we=%b rd=%0d data=%h expected 1/20/0badf00d",
               rf_we, rf_rd_addr, rf_wdata);
    end
    @(posedge clk); #1;
  endtask

  // Random ops with random memory latencies; busy cycles carry noise on in_valid/rsp_valid.
  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic rw, mr, mw, err, exp_we;
      logic [4:0] rd;
      logic [2:0] f3;
      logic [31:0] alu, sd, rdata;
      int kind, rlat, slat;
      kind = $urandom % 8;
      mr = (kind >= 2 && kind <= 4) || kind == 7;
      mw = (kind == 5 || kind == 6) || kind == 7;
      rw = $urandom % 2;
      rd = 5'($urandom);
      alu = $urandom; sd = $urandom; rdata = $urandom;
      f3 = 3'($urandom);
      rlat = $urandom % 4; slat = $urandom % 4;
      err = model_err(mr, mw, f3, alu);
      exp_we = rw && (rd != 0);
      drive_op(rw, rd, alu, mr, mw, f3, sd);
      checks++;
      if (mem_err !== err) begin
        errors++;
        $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", i, mem_err, err);
      end
      if (!(mr || mw)) begin
        checks++;
        if ({rf_we, in_ready} !== {exp_we, 1'b0} || (exp_we && {rf_rd_addr, rf_wdata} !== {rd, alu})) begin
          errors++;
          $display("[TB] FAIL rnd_alu[%0d]: got we=%b rd=%0d data=%h expected we=%b rd=%0d data=%h",
                   i, rf_we, rf_rd_addr, rf_wdata, exp_we, rd, alu);
        end
        @(posedge clk); #1;
      end else if (err) begin
        checks++;
        if ({dmem_req_valid, rf_we, in_ready} !== 3'b001) begin
          errors++;
          $display("[TB] FAIL rnd_illegal[%0d]: got v/we/rdy=%b expected 001", i, {dmem_req_valid, rf_we, in_ready});
        end
      end else begin
        for (int c = 0; c <= rlat; c++) begin
          dmem_req_ready = (c == rlat);
          dmem_rsp_valid = 1'($urandom); dmem_rsp_rdata = $urandom;
          in_valid = 1'($urandom);
          checks++;
          if ({dmem_req_valid, dmem_req_we, dmem_req_addr, rf_we} !== {1'b1, mw, alu & 32'hFFFF_FFFC, 1'b0} ||
              (mw && {dmem_req_be, dmem_req_wdata} !== {model_be(f3, alu), model_wdata(f3, sd)})) begin
            errors++;
            $display("[TB] FAIL rnd_req[%0d]: got v=%b we=%b addr=%h be=%b wd=%h expected addr=%h be=%b wd=%h",
                     i, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
                     alu & 32'hFFFF_FFFC, model_be(f3, alu), model_wdata(f3, sd));
          end
          @(posedge clk); #1;
          dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; in_valid = 1'b0;
        end
        if (mw) begin
          checks++;
          if ({in_ready, dmem_req_valid, dmem_req_be, dmem_req_wdata, rf_we} !== {1'b1, 1'b0, 4'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rnd_store_done[%0d]: got rdy=%b v=%b be=%b wd=%h we=%b", i,
                     in_ready, dmem_req_valid, dmem_req_be, dmem_req_wdata, rf_we);
          end
        end else begin
          for (int c = 0; c <= slat; c++) begin
            checks++;
            if ({in_ready, dmem_req_valid, rf_we} !== 3'b000) begin
              errors++;
              $display("[TB] FAIL rnd_wait[%0d]: got rdy/v/we=%b expected 000", i, {in_ready, dmem_req_valid, rf_we});
            end
            dmem_rsp_valid = (c == slat);
            dmem_rsp_rdata = (c == slat) ? rdata : $urandom;
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0; in_valid = 1'b0;
          end
          checks++;
          if ({rf_we, in_ready} !== {exp_we, 1'b0} ||
              (exp_we && {rf_rd_addr, rf_wdata} !== {rd, model_load(f3, alu, rdata)})) begin
            errors++;
            $display("[TB] FAIL rnd_load_wb[%0d]: got we=%b rd=%0d data=%h expected we=%b rd=%0d data=%h",
                     i, rf_we, rf_rd_addr, rf_wdata, exp_we, rd, model_load(f3, alu, rdata));
          end
          @(posedge clk); #1;
          checks++;
          if ({in_ready, rf_we} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rnd_load_idle[%0d]: got rdy/we=%b expected 10", i, {in_ready, rf_we});
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu_op;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_rd_zero;
    test_reset_in_wait;
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  input  1 / in_ready  output  1  upstream (EX) handshake; transfer when both high.
REQ-004 SHALL have: in_rd_addr  input  5 / in_reg_write  input  1  destination register, write enable.
REQ-005 SHALL have: in_alu_result  input  32  ALU result or memory byte address.
REQ-006 SHALL have: in_mem_read  input  1 / in_mem_write  input  1 / in_funct3  input  3  load/store type (RV32I encoding).
REQ-007 SHALL have: in_store_data  input  32  rs2 value for stores.
REQ-008 SHALL have: dmem_req_valid  output  1 / dmem_req_ready  input  1 / dmem_req_we  output  1  data-memory request handshake.
REQ-009 SHALL have: dmem_req_addr  output  32 (bits[1:0]=0) / dmem_req_wdata  output  32 / dmem_req_be  output  4  byte enables.
REQ-010 SHALL have: dmem_rsp_valid  input  1 / dmem_rsp_rdata  input  32  load response, one-cycle pulse.
REQ-011 SHALL have: rf_we  output  1 / rf_rd_addr  output  5 / rf_wdata  output  32  register-file write port.
REQ-012 SHALL have: mem_err  output  1  one-cycle pulse on misaligned or illegal-funct3 access.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, WB; in_ready = (state==IDLE).
REQ-014 On accept in IDLE SHALL capture all in_* fields into internal registers.
REQ-015 Accepted non-memory op (mem_read=mem_write=0) SHALL go IDLE->WB; rf_we asserted exactly the cycle after acceptance.
REQ-016 Accepted legal, aligned load or store SHALL go IDLE->REQ.
REQ-017 In REQ: dmem_req_valid=1, addr={captured[31:2],2'b00}, we=mem_write; all held stable until dmem_req_ready.
REQ-018 REQ + ready: store -> IDLE (no register write); load -> WAIT.
REQ-019 WAIT: on dmem_rsp_valid capture extended load data -> WB; wait indefinitely otherwise.
REQ-020 WB: rf_we = reg_write && rd!=0, rf_rd_addr=captured rd, rf_wdata=ALU result (non-mem) or load data; next state IDLE.
REQ-021 rf_we SHALL be 0 in all states other than WB.
REQ-022 Load extraction by captured addr[1:0]: LB(000)/LBU(100) select byte lane addr[1:0], sign-/zero-extend; LH(001)/LHU(101) select halfword addr[1], sign-/zero-extend; LW(010) full word.
REQ-023 Stores: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=4'b0011<<addr[1:0], wdata=halfword replicated x2; SW be=4'b1111, wdata=store data.
REQ-024 Misaligned (half addr[0]=1, word addr[1:0]!=0) or illegal funct3 (load 011/110/111, store 011-111) SHALL issue no request, no write, pulse mem_err the cycle after acceptance, stay IDLE.
REQ-025 in_mem_read and in_mem_write both high SHALL be treated as illegal (REQ-024 behaviour).
REQ-026 dmem_rsp_valid outside WAIT SHALL be ignored.
REQ-027 dmem_req_be and dmem_req_wdata SHALL be 0 when dmem_req_valid=0.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, clear all captured registers and drive dmem_req_valid=0, rf_we=0, mem_err=0, in_ready=0 while asserted.
REQ-029 Reset mid-transaction (REQ or WAIT) SHALL abandon the access; no rf write after release; in_ready=1 first cycle after release.

Verification
REQ-030 ALU op rd=5, result 0x1234_5678 accepted cycle N -> rf_we=1, rd=5, wdata=0x1234_5678 at N+1; in_ready=1 at N+2.
REQ-031 LB addr 0x103, rsp rdata 0x80FF_0000 -> be unused, dmem_req_addr=0x100, rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-032 SH addr 0x202, data 0xAAAA_BEEF, dmem_req_ready low 3 cycles -> req held 4 cycles, be=4'b1100, wdata=0xBEEF_BEEF, no rf_we.
REQ-033 LW addr 0x101 -> no dmem_req_valid, mem_err=1 for one cycle, rf_we stays 0.
REQ-034 ALU op rd=0 -> WB state entered, rf_we=0.
REQ-035 rst_n low during WAIT, then late dmem_rsp_valid -> no rf_we, FSM IDLE, next op processed normally.
